// File: rtl/ifetch_buffer_pkg.sv
// ifetch_buffer_pkg: shared definitions for the instruction prefetch buffer.
//   `ADDR_SIZE / `INSTR_SIZE : datapath address and instruction widths (32)
//   IFB_NOP                  : instruction presented when nothing is valid
//   IFB_DEFAULT_RESET_PC     : default first fetch address
//   ifb_state_e              : RST / RUN / DRAIN control states
//   ifb_entry_t              : one queue entry {instruction, pc}
// Optional feature macro used by the top level: IFB_BYPASS_EN.
`ifndef IFB_DEFINES_SVH
`define IFB_DEFINES_SVH
`define ADDR_SIZE 32
`define INSTR_SIZE 32
`endif

package ifetch_buffer_pkg;

  localparam logic [`INSTR_SIZE-1:0] IFB_NOP              = 32'h0000_0013;
  localparam logic [`ADDR_SIZE-1:0]  IFB_DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFB_RST   = 2'd0,
    IFB_RUN   = 2'd1,
    IFB_DRAIN = 2'd2
  } ifb_state_e;

  typedef struct packed {
    logic [`INSTR_SIZE-1:0] instr;
    logic [`ADDR_SIZE-1:0]  pc;
  } ifb_entry_t;

  // Word-align an address (instruction fetches are always word granular).
  function automatic logic [`ADDR_SIZE-1:0] ifb_align(input logic [`ADDR_SIZE-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Sequential PC; wraps naturally from 32'hFFFF_FFFC to 0.
  function automatic logic [`ADDR_SIZE-1:0] ifb_next_pc(input logic [`ADDR_SIZE-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_buffer_fifo.sv
// ifb_fifo: synchronous FIFO with flush, used as the fetch queue.
//   clk, reset      : clock and synchronous active-high reset
//   flush           : empty the queue this edge (wins over push/pop)
//   push, wdata     : write tail (ignored when full)
//   pop, rdata      : remove head (ignored when empty); rdata is the head
//   full, empty     : occupancy flags
//   count           : number of valid entries
// DEPTH must be a power of two so the pointers wrap on their own.
module ifb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // Next-state: pointer/count update, flush overriding push and pop.
  always_comb begin
    mem_d     = mem_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    if (flush) begin
      rptr_d  = {PW{1'b0}};
      wptr_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + PW'(1'b1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PW'(1'b1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      rptr_q  <= {PW{1'b0}};
      wptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: in-order instruction prefetcher between imem and IF.
//   clk, reset              : clock, synchronous active-high reset
//   imem_req/addr/gnt       : fetch request handshake (addr held until gnt)
//   imem_rvalid/rdata       : in-order fetch responses
//   redirect, redirect_pc   : taken branch/jump; flush and restart fetching
//   instr_valid/instr/pc    : queue head towards IF (NOP / pc 0 when empty)
//   instr_ready             : IF consumes the head
// Optional: define IFB_BYPASS_EN to let a response reach IF in the same
// cycle when the queue is empty.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          MAX_OUTST = 2,
  parameter logic [`ADDR_SIZE-1:0] RESET_PC = IFB_DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [`ADDR_SIZE-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [`INSTR_SIZE-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [`ADDR_SIZE-1:0]  redirect_pc,
  output logic                   instr_valid,
  output logic [`INSTR_SIZE-1:0] instr,
  output logic [`ADDR_SIZE-1:0]  instr_pc,
  input  logic                   instr_ready
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTST+2);

  ifb_state_e             state_q, state_d;
  logic [`ADDR_SIZE-1:0]  fetch_pc_q, fetch_pc_d;
  logic [`ADDR_SIZE-1:0]  resp_pc_q, resp_pc_d;
  logic [OW-1:0]          outst_q, outst_d;
  logic [OW-1:0]          discard_q, discard_d;

  logic                   req_s, gnt_s, rsp_s, drop_s, acc_s, byp_s;
  logic                   push_s, pop_s;
  logic                   fifo_full_s, fifo_empty_s;
  logic [CW-1:0]          count_s;
  ifb_entry_t             head_s, wentry_s;

  assign wentry_s = '{instr: imem_rdata, pc: resp_pc_q};

  ifb_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(ifb_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push_s),
    .wdata (wentry_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s)
  );

  // Handshake decode: request credit, response classification, queue moves.
  always_comb begin
    req_s = 1'b0;
    // Space is reserved for every live fetch, so a push can never overflow;
    // stale fetches still occupy memory-side credit until they drain.
    if (!reset && (state_q != IFB_RST) && !redirect
        && ((32'(count_s) + 32'(outst_q)) < 32'(DEPTH))
        && ((32'(outst_q) + 32'(discard_q)) < 32'(MAX_OUTST))) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    gnt_s  = req_s & imem_gnt;
    // A response with nothing in flight is a protocol error and is ignored.
    rsp_s  = imem_rvalid & ((outst_q != {OW{1'b0}}) | (discard_q != {OW{1'b0}}));
    drop_s = rsp_s & (discard_q != {OW{1'b0}});
    acc_s  = rsp_s & (discard_q == {OW{1'b0}});
`ifdef IFB_BYPASS_EN
    byp_s  = acc_s & fifo_empty_s & ~redirect;
`else
    byp_s  = 1'b0;
`endif
    push_s = acc_s & ~redirect & ~fifo_full_s & ~(byp_s & instr_ready);
    pop_s  = ~fifo_empty_s & instr_ready;
  end

  // Next-state for PCs and credit counters; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = ifb_align(redirect_pc);
      resp_pc_d  = ifb_align(redirect_pc);
      outst_d    = {OW{1'b0}};
      // Everything still in flight becomes stale; a response landing in this
      // very cycle is itself dropped, so it leaves the stale total.
      discard_d  = OW'(32'(outst_q) + 32'(discard_q) + 32'(gnt_s) - 32'(rsp_s));
    end else begin
      if (gnt_s) begin
        fetch_pc_d = ifb_next_pc(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (acc_s) begin
        resp_pc_d = ifb_next_pc(resp_pc_q);
      end else begin
        resp_pc_d = resp_pc_q;
      end
      outst_d   = OW'(32'(outst_q) + 32'(gnt_s) - 32'(acc_s));
      discard_d = OW'(32'(discard_q) - 32'(drop_s));
    end
  end

  // Control FSM next state: DRAIN while stale responses are pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IFB_RST:   state_d = IFB_RUN;
      IFB_RUN,
      IFB_DRAIN: state_d = (discard_d != {OW{1'b0}}) ? IFB_DRAIN : IFB_RUN;
      default:   state_d = IFB_RST;
    endcase
  end

  // Output mux: queue head first, then (optionally) the bypassed response.
  always_comb begin
    instr_valid = 1'b0;
    instr       = IFB_NOP;
    instr_pc    = {`ADDR_SIZE{1'b0}};
    if (!fifo_empty_s) begin
      instr_valid = 1'b1;
      instr       = head_s.instr;
      instr_pc    = head_s.pc;
    end else if (byp_s) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = resp_pc_q;
    end else begin
      instr_valid = 1'b0;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IFB_RST;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= {OW{1'b0}};
      discard_q  <= {OW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer (default build, DEPTH=4, MAX_OUTST=2).
// Memory model grants under gnt_en and answers one cycle after the grant
// unless rsp_en holds responses back.
module tb_ifetch_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        gnt_en;
  logic        rsp_en;
  exp_t        sb[$];
  logic [31:0] pend[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  ifetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back('{pc: pc, data: mem_data(pc)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory: record handshakes (inputs are stable by the falling edge).
  initial forever begin
    @(negedge clk);
    if (!reset && imem_req && imem_gnt) pend.push_back(imem_addr);
  end

  // Memory: drive responses in order, one per cycle.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else begin
        if (imem_rvalid && pend.size() != 0) void'(pend.pop_front());
        if (rsp_en && pend.size() != 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_data(pend[0]);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'h0;
        end
      end
    end
  end

  // Monitor: every consumed head must match the next expected entry.
  initial forever begin
    @(negedge clk);
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h with empty scoreboard", instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_instr", instr, e.data);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    gnt_en      = 1'b0;
    rsp_en      = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) cyc();
    #2;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", instr_pc, 32'h0);

    // c0: reset released, FSM still in RST so no request yet.
    cyc();
    reset = 1'b0; gnt_en = 1'b1; instr_ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4);
    #2;
    check("c0_req", {31'd0, imem_req}, 32'd0);
    check("c0_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2;                                   // c1
    check("c1_req", {31'd0, imem_req}, 32'd1);
    check("c1_addr", imem_addr, 32'h0);
    check("c1_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2;                                   // c2
    check("c2_addr", imem_addr, 32'h4);
    check("c2_valid", {31'd0, instr_valid}, 32'd0);
    // c3..c5: grant withheld, request and address 0x8 must hold.
    cyc(); gnt_en = 1'b0; #2;                    // c3
    check("c3_valid", {31'd0, instr_valid}, 32'd1);
    check("c3_pc", instr_pc, 32'h0);
    check("hold_req", {31'd0, imem_req}, 32'd1);
    check("hold_addr", imem_addr, 32'h8);
    for (int i = 0; i < 2; i++) begin            // c4, c5
      cyc(); #2;
      check("hold_req", {31'd0, imem_req}, 32'd1);
      check("hold_addr", imem_addr, 32'h8);
    end
    cyc(); gnt_en = 1'b1;                        // c6
    for (int i = 2; i < 8; i++) push_exp(32'(i * 4));
    #2;
    check("gnt_addr", imem_addr, 32'h8);
    cyc(); #2;                                   // c7
    check("post_gnt_addr", imem_addr, 32'hC);
    // c8..c17: IF stalled; queue fills to DEPTH and requests stop.
    cyc(); instr_ready = 1'b0;                   // c8
    repeat (9) cyc();                            // c17
    #2;
    check("stall_req", {31'd0, imem_req}, 32'd0);
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    check("stall_pc", instr_pc, 32'h8);
    check("stall_instr", instr, mem_data(32'h8));
    cyc(); instr_ready = 1'b1;                   // c18
    repeat (4) cyc();                            // c22
    rsp_en = 1'b0;
    cyc();                                       // c23
    // c24: redirect with two fetches (0x20, 0x24) still outstanding.
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    push_exp(32'h100);
    #2;
    check("redir_req", {31'd0, imem_req}, 32'd0);
    cyc(); redirect = 1'b0; rsp_en = 1'b1; #2;   // c25
    check("drain_req", {31'd0, imem_req}, 32'd0);
    cyc(); #2;                                   // c26
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h100);
    cyc();                                       // c27
    // c28: redirect coincides with a live response (0x104) and a pop.
    cyc();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    #2;
    check("c28_valid", {31'd0, instr_valid}, 32'd1);
    check("c28_pc", instr_pc, 32'h100);
    cyc(); redirect = 1'b0; #2;                  // c29
    check("flush_valid", {31'd0, instr_valid}, 32'd0);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    cyc(); #2;                                   // c30
    check("c30_valid", {31'd0, instr_valid}, 32'd0);
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    cyc(); #2;                                   // c31
    check("lat_valid", {31'd0, instr_valid}, 32'd1);
    check("lat_pc", instr_pc, 32'hFFFF_FFF8);
    check("wrap_addr2", imem_addr, 32'h0);
    cyc(); gnt_en = 1'b0;                        // c32
    repeat (8) cyc();
    #2;
    check("end_req", {31'd0, imem_req}, 32'd1);
    check("end_addr", imem_addr, 32'h4);
    check("end_valid", {31'd0, instr_valid}, 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
    check("mem_pending", 32'(pend.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
